// File: rtl/ni_param.sv
// ni_param: network interface between one GPU endpoint and its leaf router port.
//
// TX path: GPU words tagged with a destination GPU ID are rewritten into routing-header
// flits (addr = id + ADDR_BASE - 1) and sent to the router. Words whose ID is outside
// 1..NUM_GPUS are consumed and counted in drop_bad_dest_cnt.
// RX path: router flits whose header equals this endpoint's address are rewritten back
// into GPU-ID-tagged words. Other flits are consumed and counted in drop_misroute_cnt.
// Each path has a FIFO_DEPTH-entry FIFO followed by a registered valid/ready output stage.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   gpu_data_in/valid_in/ready_out  GPU -> NI words
//   router_data_out/valid/ready_in  NI -> router flits
//   router_data_in/valid/ready_out  router -> NI flits
//   gpu_data_out/valid_out/ready_in NI -> GPU words
//   tx_level, rx_level              FIFO occupancy (output register not included)
//   drop_bad_dest_cnt               saturating count of invalid-destination GPU words
//   drop_misroute_cnt               saturating count of flits not addressed to GPU_ID
module ni_param #(
    parameter int unsigned GPU_ID     = 21,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned HEADER_W   = 6,
    parameter int unsigned NUM_GPUS   = 32,
    parameter int unsigned ADDR_BASE  = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_W-1:0]                   gpu_data_in,
    input  logic                                gpu_valid_in,
    output logic                                gpu_ready_out,
    output logic [DATA_W-1:0]                   router_data_out,
    output logic                                router_valid_out,
    input  logic                                router_ready_in,
    input  logic [DATA_W-1:0]                   router_data_in,
    input  logic                                router_valid_in,
    output logic                                router_ready_out,
    output logic [DATA_W-1:0]                   gpu_data_out,
    output logic                                gpu_valid_out,
    input  logic                                gpu_ready_in,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     tx_level,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     rx_level,
    output logic [CNT_W-1:0]                    drop_bad_dest_cnt,
    output logic [CNT_W-1:0]                    drop_misroute_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PAY_W = DATA_W - HEADER_W;

    localparam logic [HEADER_W-1:0] ADDR_OFF = HEADER_W'(ADDR_BASE - 1);
    localparam logic [HEADER_W-1:0] MAX_ID   = HEADER_W'(NUM_GPUS);
    localparam logic [HEADER_W-1:0] OWN_ADDR = HEADER_W'(GPU_ID + ADDR_BASE - 1);
    localparam logic [LVL_W-1:0]    FULL_LVL = LVL_W'(FIFO_DEPTH);

    // ---------------- TX path ----------------
    logic [DATA_W-1:0]   tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    tx_wr_ptr, tx_rd_ptr;
    logic [HEADER_W-1:0] tx_dest, tx_hdr;
    logic [DATA_W-1:0]   tx_wdata;
    logic                tx_dest_ok, tx_accept, tx_push, tx_drop, tx_pop;

    always_comb begin
        tx_dest       = gpu_data_in[DATA_W-1 -: HEADER_W];
        tx_hdr        = tx_dest + ADDR_OFF;
        tx_wdata      = {tx_hdr, gpu_data_in[PAY_W-1:0]};
        tx_dest_ok    = (tx_dest != '0) && (tx_dest <= MAX_ID);
        gpu_ready_out = (tx_level != FULL_LVL);
        tx_accept     = gpu_valid_in && gpu_ready_out;
        tx_push       = tx_accept && tx_dest_ok;
        tx_drop       = tx_accept && !tx_dest_ok;
        // Head moves into the output stage whenever that stage is empty or draining.
        tx_pop        = (tx_level != '0) && (!router_valid_out || router_ready_in);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr         <= '0;
            tx_rd_ptr         <= '0;
            tx_level          <= '0;
            router_data_out   <= '0;
            router_valid_out  <= 1'b0;
            drop_bad_dest_cnt <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (tx_push && !tx_pop)      tx_level <= tx_level + 1'b1;
            else if (!tx_push && tx_pop) tx_level <= tx_level - 1'b1;
            if (tx_pop) begin
                router_data_out  <= tx_mem[tx_rd_ptr];
                router_valid_out <= 1'b1;
            end else if (router_ready_in) begin
                router_valid_out <= 1'b0;
            end
            if (tx_drop && (drop_bad_dest_cnt != '1)) begin
                drop_bad_dest_cnt <= drop_bad_dest_cnt + 1'b1;
            end
        end
    end

    // ---------------- RX path ----------------
    logic [DATA_W-1:0]   rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rx_wr_ptr, rx_rd_ptr;
    logic [HEADER_W-1:0] rx_hdr, rx_id;
    logic [DATA_W-1:0]   rx_wdata;
    logic                rx_match, rx_accept, rx_push, rx_drop, rx_pop;

    always_comb begin
        rx_hdr           = router_data_in[DATA_W-1 -: HEADER_W];
        rx_id            = rx_hdr - ADDR_OFF;
        rx_wdata         = {rx_id, router_data_in[PAY_W-1:0]};
        rx_match         = (rx_hdr == OWN_ADDR);
        router_ready_out = (rx_level != FULL_LVL);
        rx_accept        = router_valid_in && router_ready_out;
        rx_push          = rx_accept && rx_match;
        rx_drop          = rx_accept && !rx_match;
        rx_pop           = (rx_level != '0) && (!gpu_valid_out || gpu_ready_in);
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr         <= '0;
            rx_rd_ptr         <= '0;
            rx_level          <= '0;
            gpu_data_out      <= '0;
            gpu_valid_out     <= 1'b0;
            drop_misroute_cnt <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_push && !rx_pop)      rx_level <= rx_level + 1'b1;
            else if (!rx_push && rx_pop) rx_level <= rx_level - 1'b1;
            if (rx_pop) begin
                gpu_data_out  <= rx_mem[rx_rd_ptr];
                gpu_valid_out <= 1'b1;
            end else if (gpu_ready_in) begin
                gpu_valid_out <= 1'b0;
            end
            if (rx_drop && (drop_misroute_cnt != '1)) begin
                drop_misroute_cnt <= drop_misroute_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ni_param.sv
// Self-checking bench for ni_param (default parameters). A queue-based reference model
// tracks every buffered word with the edge at which it was accepted; a word is visible at
// the output from the edge after acceptance once all older words have left.
module tb_ni_param;

    localparam int DEPTH   = 8;
    localparam int OWN_ID  = 21;
    localparam int BASE    = 4;
    localparam int NGPU    = 32;
    localparam int CNT_MAX = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gpu_data_in, router_data_in;
    logic        gpu_valid_in, router_ready_in, router_valid_in, gpu_ready_in;
    logic        gpu_ready_out, router_valid_out, router_ready_out, gpu_valid_out;
    logic [15:0] router_data_out, gpu_data_out;
    logic [3:0]  tx_level, rx_level;
    logic [7:0]  drop_bad_dest_cnt, drop_misroute_cnt;

    always #5 clk = ~clk;

    ni_param dut (
        .clk               (clk),
        .reset             (reset),
        .gpu_data_in       (gpu_data_in),
        .gpu_valid_in      (gpu_valid_in),
        .gpu_ready_out     (gpu_ready_out),
        .router_data_out   (router_data_out),
        .router_valid_out  (router_valid_out),
        .router_ready_in   (router_ready_in),
        .router_data_in    (router_data_in),
        .router_valid_in   (router_valid_in),
        .router_ready_out  (router_ready_out),
        .gpu_data_out      (gpu_data_out),
        .gpu_valid_out     (gpu_valid_out),
        .gpu_ready_in      (gpu_ready_in),
        .tx_level          (tx_level),
        .rx_level          (rx_level),
        .drop_bad_dest_cnt (drop_bad_dest_cnt),
        .drop_misroute_cnt (drop_misroute_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] d;
        int          t;
    } ent_t;

    ent_t txq[$];
    ent_t rxq[$];
    int   bad_m = 0;
    int   mis_m = 0;
    int   cyc   = 0;   // index of the most recent clock edge

    function automatic bit tx_vis();
        return (txq.size() > 0) && (txq[0].t < cyc);
    endfunction
    function automatic bit rx_vis();
        return (rxq.size() > 0) && (rxq[0].t < cyc);
    endfunction
    function automatic int tx_lvl();
        return txq.size() - (tx_vis() ? 1 : 0);
    endfunction
    function automatic int rx_lvl();
        return rxq.size() - (rx_vis() ? 1 : 0);
    endfunction
    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_clear();
        txq.delete();
        rxq.delete();
        bad_m = 0;
        mis_m = 0;
    endtask

    task automatic check_outputs();
        chk("tx_valid", 32'(router_valid_out), 32'(tx_vis()));
        if (tx_vis()) chk("tx_data", 32'(router_data_out), 32'(txq[0].d));
        chk("tx_ready", 32'(gpu_ready_out), 32'(tx_lvl() < DEPTH));
        chk("tx_level", 32'(tx_level), 32'(tx_lvl()));
        chk("rx_valid", 32'(gpu_valid_out), 32'(rx_vis()));
        if (rx_vis()) chk("rx_data", 32'(gpu_data_out), 32'(rxq[0].d));
        chk("rx_ready", 32'(router_ready_out), 32'(rx_lvl() < DEPTH));
        chk("rx_level", 32'(rx_level), 32'(rx_lvl()));
        chk("bad_cnt", 32'(drop_bad_dest_cnt), 32'(sat(bad_m)));
        chk("mis_cnt", 32'(drop_misroute_cnt), 32'(sat(mis_m)));
    endtask

    // Apply the current inputs across one clock edge, updating the model to match.
    task automatic step();
        bit tv, tr, rv, rr;
        int dest;
        int hdr;
        tv = tx_vis();
        tr = tx_lvl() < DEPTH;
        rv = rx_vis();
        rr = rx_lvl() < DEPTH;
        if (tv && router_ready_in) void'(txq.pop_front());
        if (gpu_valid_in && tr) begin
            dest = int'(gpu_data_in[15:10]);
            if (dest >= 1 && dest <= NGPU)
                txq.push_back('{d: {6'(dest + BASE - 1), gpu_data_in[9:0]}, t: cyc + 1});
            else
                bad_m++;
        end
        if (rv && gpu_ready_in) void'(rxq.pop_front());
        if (router_valid_in && rr) begin
            hdr = int'(router_data_in[15:10]);
            if (hdr == OWN_ID + BASE - 1)
                rxq.push_back('{d: {6'(hdr - BASE + 1), router_data_in[9:0]}, t: cyc + 1});
            else
                mis_m++;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle_inputs();
        gpu_valid_in    = 1'b0;
        router_valid_in = 1'b0;
        gpu_data_in     = '0;
        router_data_in  = '0;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs();
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        bit          rx;
        logic [15:0] din;
        bit          pass;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int acc, got;
        logic [15:0] held_d;
        bit held;

        vecs[0] = '{0, {6'd22, 10'h155}, 1, {6'b011001, 10'h155}};
        vecs[1] = '{0, {6'd1,  10'h3ff}, 1, {6'd4,  10'h3ff}};
        vecs[2] = '{0, {6'd32, 10'h001}, 1, {6'd35, 10'h001}};
        vecs[3] = '{0, {6'd0,  10'h0aa}, 0, 16'h0};
        vecs[4] = '{0, {6'd33, 10'h123}, 0, 16'h0};
        vecs[5] = '{0, {6'd63, 10'h3c3}, 0, 16'h0};
        vecs[6] = '{1, {6'b011000, 10'h2aa}, 1, {6'd21, 10'h2aa}};
        vecs[7] = '{1, {6'b011001, 10'h111}, 0, 16'h0};
        vecs[8] = '{1, {6'd0,  10'h055}, 0, 16'h0};
        vecs[9] = '{1, {6'd4,  10'h0f0}, 0, 16'h0};

        reset = 1'b1;
        router_ready_in = 1'b1;
        gpu_ready_in    = 1'b1;
        idle_inputs();
        #2;
        chk("rst_tx_valid", 32'(router_valid_out), 32'd0);
        chk("rst_rx_valid", 32'(gpu_valid_out), 32'd0);
        chk("rst_tx_data", 32'(router_data_out), 32'd0);
        chk("rst_rx_data", 32'(gpu_data_out), 32'd0);
        chk("rst_gpu_ready", 32'(gpu_ready_out), 32'd1);
        chk("rst_router_ready", 32'(router_ready_out), 32'd1);
        chk("rst_levels", 32'({tx_level, rx_level}), 32'd0);
        chk("rst_counters", 32'({drop_bad_dest_cnt, drop_misroute_cnt}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single-word translation and filtering, one vector at a time.
        foreach (vecs[i]) begin
            if (vecs[i].rx) begin
                router_valid_in = 1'b1;
                router_data_in  = vecs[i].din;
            end else begin
                gpu_valid_in = 1'b1;
                gpu_data_in  = vecs[i].din;
            end
            step();
            idle_inputs();
            step();
            if (vecs[i].rx) begin
                chk($sformatf("vec%0d_valid", i), 32'(gpu_valid_out), 32'(vecs[i].pass));
                if (vecs[i].pass) chk($sformatf("vec%0d_data", i), 32'(gpu_data_out), 32'(vecs[i].dout));
            end else begin
                chk($sformatf("vec%0d_valid", i), 32'(router_valid_out), 32'(vecs[i].pass));
                if (vecs[i].pass) chk($sformatf("vec%0d_data", i), 32'(router_data_out), 32'(vecs[i].dout));
            end
            step();
            chk($sformatf("vec%0d_one_cycle", i), 32'(router_valid_out | gpu_valid_out), 32'd0);
        end
        chk("table_bad_cnt", 32'(drop_bad_dest_cnt), 32'd3);
        chk("table_mis_cnt", 32'(drop_misroute_cnt), 32'd3);
        chk("table_tx_level", 32'(tx_level), 32'd0);

        // Reset with 5 words buffered in each direction.
        router_ready_in = 1'b0;
        gpu_ready_in    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gpu_valid_in    = 1'b1;
            gpu_data_in     = {6'(i + 2), 10'(i * 11)};
            router_valid_in = 1'b1;
            router_data_in  = {6'd24, 10'(i * 13)};
            step();
        end
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("midrst_valids", 32'({router_valid_out, gpu_valid_out}), 32'd0);
        chk("midrst_levels", 32'({tx_level, rx_level}), 32'd0);
        chk("midrst_counters", 32'({drop_bad_dest_cnt, drop_misroute_cnt}), 32'd0);
        chk("midrst_readies", 32'({gpu_ready_out, router_ready_out}), 32'd3);
        #1;
        reset = 1'b0;
        router_ready_in = 1'b1;
        gpu_ready_in    = 1'b1;
        gpu_valid_in    = 1'b1;
        gpu_data_in     = {6'd7, 10'h2c3};
        step();
        idle_inputs();
        step();
        chk("postrst_valid", 32'(router_valid_out), 32'd1);
        chk("postrst_data", 32'(router_data_out), 32'({6'd10, 10'h2c3}));
        step();

        // Backpressure: 10 words offered, only FIFO_DEPTH + 1 fit.
        router_ready_in = 1'b0;
        acc = 0;
        for (int c = 0; c < 14; c++) begin
            gpu_valid_in = (acc < 10);
            gpu_data_in  = {6'(acc + 1), 10'(acc * 37 + 5)};
            if (gpu_ready_out && acc < 10) acc++;
            step();
        end
        idle_inputs();
        chk("bp_accepted", 32'(acc), 32'd9);
        chk("bp_level", 32'(tx_level), 32'd8);
        chk("bp_ready_low", 32'(gpu_ready_out), 32'd0);
        got = 0;
        for (int c = 0; c < 80 && got < 9; c++) begin
            router_ready_in = 1'($urandom_range(0, 1));
            held   = router_valid_out && !router_ready_in;
            held_d = router_data_out;
            if (router_valid_out && router_ready_in) begin
                chk($sformatf("bp_order%0d", got), 32'(router_data_out),
                    32'({6'(got + BASE), 10'(got * 37 + 5)}));
                got++;
            end
            step();
            if (held) begin
                chk("bp_hold_valid", 32'(router_valid_out), 32'd1);
                chk("bp_hold_data", 32'(router_data_out), 32'(held_d));
            end
        end
        chk("bp_drained", 32'(got), 32'd9);
        router_ready_in = 1'b1;
        step();

        // Streaming at level 1, then at full, across pointer wrap.
        for (int i = 0; i < 24; i++) begin
            gpu_valid_in = 1'b1;
            gpu_data_in  = {6'((i % NGPU) + 1), 10'(i * 29)};
            step();
            if (i >= 2) chk("stream_lvl1", 32'(tx_level), 32'd1);
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
        router_ready_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            gpu_valid_in = 1'b1;
            gpu_data_in  = {6'(((i + 5) % NGPU) + 1), 10'(i * 71)};
            step();
        end
        router_ready_in = 1'b1;
        for (int i = 0; i < 22; i++) begin
            gpu_valid_in = 1'b1;
            gpu_data_in  = {6'(((i + 9) % NGPU) + 1), 10'(i * 53 + 1)};
            step();
            if (i >= 1) chk("stream_full", 32'(tx_level), 32'd7);
        end
        idle_inputs();
        for (int i = 0; i < 12; i++) step();

        // Counter saturation in both directions.
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            gpu_valid_in    = 1'b1;
            gpu_data_in     = {6'd0, 10'(i)};
            router_valid_in = 1'b1;
            router_data_in  = {6'd0, 10'(i)};
            step();
        end
        idle_inputs();
        chk("sat_bad", 32'(drop_bad_dest_cnt), 32'd255);
        chk("sat_mis", 32'(drop_misroute_cnt), 32'd255);

        // Randomized traffic in both directions against the model.
        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            gpu_valid_in    = ($urandom_range(0, 9) < 7);
            gpu_data_in     = {6'($urandom_range(0, 40)), 10'($urandom)};
            router_valid_in = ($urandom_range(0, 9) < 7);
            router_data_in  = {(($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd24), 10'($urandom)};
            router_ready_in = ($urandom_range(0, 9) < 6);
            gpu_ready_in    = ($urandom_range(0, 9) < 6);
            step();
        end
        idle_inputs();
        router_ready_in = 1'b1;
        gpu_ready_in    = 1'b1;
        for (int i = 0; i < 12; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
